// File: rtl/tff_mod_counter.sv
// Modulo-MOD up/down counter built from T flip-flops: every bit toggles under
// t_vec, which is the XOR of the current count and the selected next count.
module tff_mod_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_b,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             ld_err
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);
    // One extra bit so that MOD == 2**WIDTH is representable in the range check.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] next_q;
    logic             wrap;
    logic             load_oor;

    always_comb begin
        load_oor = ({1'b0, d_in} >= MOD_X);
        next_q   = q;
        wrap     = 1'b0;
        if (load) begin
            next_q = load_oor ? MAX_Q : d_in;
        end else if (en) begin
            if (up_dn) begin
                if (q == MAX_Q) begin
                    next_q = '0;
                    wrap   = 1'b1;
                end else begin
                    next_q = q + 1'b1;
                end
            end else begin
                if (q == '0) begin
                    next_q = MAX_Q;
                    wrap   = 1'b1;
                end else begin
                    next_q = q - 1'b1;
                end
            end
        end
    end

    assign t_vec = q ^ next_q;
    assign q_b   = ~q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            tc     <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            q      <= q ^ t_vec;
            tc     <= wrap;
            ld_err <= load & load_oor;
        end
    end

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter (WIDTH=4, MOD=10): directed plan steps followed by
// random stimulus, all checked against a modulo-arithmetic reference model.
module tb_tff_mod_counter;

    localparam int MODV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] d_in = '0;
    logic [3:0] q, q_b, t_vec;
    logic       tc, ld_err;

    int tests = 0;
    int fails = 0;
    int mq = 0;
    int mtc = 0;
    int merr = 0;

    always #10 clk = ~clk;

    tff_mod_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d_in(d_in),
        .q(q), .q_b(q_b), .t_vec(t_vec), .tc(tc), .ld_err(ld_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check toggle mask before the edge, check
    // registered outputs at the following negedge.
    task automatic step(input logic r, input logic l, input logic e, input logic u,
                        input logic [3:0] d);
        int nq, ntc, nerr;
        rst = r; load = l; en = e; up_dn = u; d_in = d;
        if (r) begin
            nq = 0; ntc = 0; nerr = 0;
        end else if (l) begin
            nq   = (int'(d) < MODV) ? int'(d) : MODV - 1;
            nerr = (int'(d) < MODV) ? 0 : 1;
            ntc  = 0;
        end else if (e) begin
            nq   = u ? (mq + 1) % MODV : (mq + MODV - 1) % MODV;
            ntc  = u ? int'(mq == MODV - 1) : int'(mq == 0);
            nerr = 0;
        end else begin
            nq = mq; ntc = 0; nerr = 0;
        end
        #1;
        if (!r) chk("t_vec", 16'(t_vec), 16'(mq ^ nq));
        @(posedge clk);
        mq = nq; mtc = ntc; merr = nerr;
        @(negedge clk);
        chk("q", 16'(q), 16'(mq));
        chk("q_b", 16'(q_b), 16'((~mq) & 15));
        chk("tc", 16'(tc), 16'(mtc));
        chk("ld_err", 16'(ld_err), 16'(merr));
    endtask

    initial begin
        @(negedge clk);

        // Reset overrides load and enable
        step(1, 1, 1, 1, 4'd5);
        step(1, 1, 1, 1, 4'd5);
        chk("rst_q", 16'(q), 16'd0);
        chk("rst_qb", 16'(q_b), 16'hF);

        // Up count 1..9,0,1,2
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 1, 1, 4'd0);
            chk("up_seq", 16'(q), 16'(i % 10));
            if (i == 9) begin
                #1 chk("up_tvec9", 16'(t_vec), 16'h9);
            end
            if (i == 10) chk("up_tc", 16'(tc), 16'd1);
        end

        // Down count from 0
        step(1, 0, 0, 0, 4'd0);
        en = 1'b1; up_dn = 1'b0;
        #1 chk("dn_tvec0", 16'(t_vec), 16'h9);
        step(0, 0, 1, 0, 4'd0);
        chk("dn_wrap_q", 16'(q), 16'd9);
        chk("dn_wrap_tc", 16'(tc), 16'd1);
        step(0, 0, 1, 0, 4'd0);
        chk("dn_q8", 16'(q), 16'd8);
        step(0, 0, 1, 0, 4'd0);
        chk("dn_q7", 16'(q), 16'd7);

        // Load range and clamp
        step(0, 1, 1, 0, 4'd7);
        chk("ld7_q", 16'(q), 16'd7);
        step(0, 1, 0, 0, 4'd13);
        chk("ld13_q", 16'(q), 16'd9);
        chk("ld13_err", 16'(ld_err), 16'd1);
        step(0, 0, 1, 1, 4'd0);
        chk("ld_wrap_q", 16'(q), 16'd0);
        chk("ld_wrap_tc", 16'(tc), 16'd1);
        chk("ld_err_clr", 16'(ld_err), 16'd0);
        step(0, 1, 0, 0, 4'd15);
        chk("ld15_q", 16'(q), 16'd9);

        // Hold then direction flips
        step(0, 1, 0, 1, 4'd4);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 4'd0);
            chk("hold_q", 16'(q), 16'd4);
            chk("hold_tvec", 16'(t_vec), 16'd0);
        end
        step(0, 0, 1, 1, 4'd0); chk("flip_q5", 16'(q), 16'd5);
        step(0, 0, 1, 0, 4'd0); chk("flip_q4", 16'(q), 16'd4);
        step(0, 0, 1, 0, 4'd0); chk("flip_q3", 16'(q), 16'd3);
        step(0, 0, 1, 1, 4'd0); chk("flip_q4b", 16'(q), 16'd4);

        // Reset at the wrap edge
        step(0, 1, 0, 1, 4'd9);
        step(1, 0, 1, 1, 4'd0);
        chk("rstwrap_q", 16'(q), 16'd0);
        chk("rstwrap_tc", 16'(tc), 16'd0);
        step(0, 0, 1, 1, 4'd0);
        chk("rstwrap_resume", 16'(q), 16'd1);

        // Loading the terminal value while counting up does not fire tc
        step(0, 1, 1, 1, 4'd9);
        chk("ldterm_tc", 16'(tc), 16'd0);
        step(0, 0, 1, 1, 4'd0);
        chk("ldterm_next_tc", 16'(tc), 16'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tff_mod_counter.md
# tff_mod_counter

Synchronous modulo up/down counter built as a bank of T flip-flops. Each bit has a toggle enable derived from the current count, direction and wrap condition. It is the stage directly downstream of the single T flip-flop: it chains toggle-type storage elements into a multi-bit divider/counter. It provides a registered count, its complement, a terminal-count pulse and a load-range error flag for the next consumer.

## Interface
- `WIDTH`, default 4, count width in bits; must satisfy 2 ≤ WIDTH ≤ 16.
- `MOD`, default 10, count modulus; must satisfy 2 ≤ MOD ≤ 2^WIDTH. The count range is 0..MOD-1.
- `clk` input, 1 bit: the only clock; all state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `en` input, 1 bit: count enable.
- `up_dn` input, 1 bit: 1 = count up, 0 = count down.
- `load` input, 1 bit: synchronous parallel load.
- `d_in` input, WIDTH bits: load value.
- `q` output, WIDTH bits: registered count.
- `q_b` output, WIDTH bits: always equal to `~q`.
- `t_vec` output, WIDTH bits: combinational toggle mask applied at the next edge, `t_vec = q ^ next_q`.
- `tc` output, 1 bit: registered terminal-count pulse.
- `ld_err` output, 1 bit: registered out-of-range load flag.

## Operation
- **Storage.** Each bit is a T flip-flop: `q[i] <= q[i] ^ t_vec[i]`. `next_q` is the only source of `t_vec`. The implementation must not contain an independent D-path that bypasses the toggle mask.
- **Priority per edge:** `rst` > `load` > `en` > hold.
- **rst = 1:** `q` = 0, `tc` = 0, `ld_err` = 0.
- **load = 1** (with `rst` = 0):
  - If `d_in` < MOD: `next_q` = `d_in`, `ld_err` = 0.
  - If `d_in` ≥ MOD: `next_q` = MOD-1, `ld_err` = 1 for exactly one cycle.
  - `tc` = 0 on a load edge.
  - `en` and `up_dn` are ignored.
- **en = 1, up_dn = 1:**
  - If `q` == MOD-1: `next_q` = 0 and `tc` = 1.
  - Otherwise `next_q` = `q` + 1 and `tc` = 0.
- **en = 1, up_dn = 0:**
  - If `q` == 0: `next_q` = MOD-1 and `tc` = 1.
  - Otherwise `next_q` = `q` - 1 and `tc` = 0.
- **Hold** (`en` = 0, no load): `next_q` = `q`, `t_vec` = 0, `tc` = 0, `ld_err` = 0.
- **Arithmetic.** Compute in WIDTH bits; wrap is governed by MOD, never by natural 2^WIDTH overflow. When MOD = 2^WIDTH, the result matches natural binary wrap.
- **Direction change.** `up_dn` may change on any cycle and takes effect at the next enabled edge. There is no pipeline and no state is carried between directions.
- **Illegal state.** No illegal state is reachable after reset, because loads are clamped.

## Timing
- **Latency.** One cycle from input sampling to `q`. `tc` and `ld_err` are registered in the same edge as the corresponding `q` update, so they are coincident with the wrapped or clamped value.
- **Pulse width.** `tc` is high for exactly one cycle per wrap. Continuous counting at MOD = 10 gives one `tc` every 10 enabled cycles.
- **`t_vec`** is valid whenever inputs are stable before the rising edge. It settles combinationally from `q`, `en`, `up_dn`, `load` and `d_in`.
- **`q_b`** is combinational from `q` and has no extra cycle.
- **Reset mid-count.** `rst` asserted at any edge clears `q`, `tc` and `ld_err` at that edge, overriding a simultaneous `load`, `en` or wrap. The count resumes from 0 on the first edge with `rst` = 0.
- **Simultaneous load and wrap.** Load wins; `tc` = 0.
- **Load into terminal value.** Loading MOD-1 while counting up does not itself produce `tc`; `tc` fires on the following enabled edge.

## Test plan
All scenarios use WIDTH = 4 and MOD = 10. Drive inputs on the negedge with a 20 ns clock period.

- **Reset:** `rst` = 1 for 2 edges with `en` = 1 and `load` = 1, `d_in` = 5 → `q` = 0, `q_b` = 4'b1111, `tc` = 0, `ld_err` = 0.
- **Up count:** `en` = 1, `up_dn` = 1 for 12 edges from 0 → `q` sequence 1..9,0,1,2. `tc` = 1 only in the cycle `q` = 0 after 9. `t_vec` = 4'b1001 while `q` = 9.
- **Down count:** `en` = 1, `up_dn` = 0 from 0 → `q` = 9 with `tc` = 1, then 8, 7. Also `t_vec` = 4'b1001 at `q` = 0.
- **Load range:**
  - `load` with `d_in` = 7 → `q` = 7, `ld_err` = 0.
  - `load` with `d_in` = 13 → `q` = 9, `ld_err` = 1 for one cycle.
  - Next enabled up edge → `q` = 0, `tc` = 1.
- **Hold and direction flip:**
  - At `q` = 4, `en` = 0 for 3 edges → `q` stays 4, `t_vec` = 0.
  - Then `en` = 1 with `up_dn` = 1,0,0,1 on successive edges → `q` = 5,4,3,4.
- **Reset mid-wrap:** at `q` = 9 with `en` = 1, `up_dn` = 1 and `rst` = 1 → `q` = 0, `tc` = 0. The next edge with `rst` = 0 gives `q` = 1.
